// File: rtl/lcd_bus_master_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_master_if
//   Request/response port of the LCD parallel bus master.
//   master modport : requesting engine (init / ID / pixel engines)
//   slave  modport : lcd_bus_master
//
//   req_valid / req_ready   request handshake, accepted when both are high
//   req_write               1 = write one word, 0 = read
//   req_rs                  write only: 0 = command, 1 = data
//   req_wdata   [DW]        write word
//   req_rd_len  [RLW]       words to read (0 -> 1, clamped to MAX_RD)
//   req_fm                  read timing: 0 = ID/register, 1 = frame memory
//   rsp_valid               one-cycle pulse when a read completes
//   rsp_rdata   [DW*MAX_RD] read words, newest word in the low DW bits
//   wr_done                 one-cycle pulse on the cycle lcd_wr rises
//   busy                    bus master not idle
// -----------------------------------------------------------------------------
interface lcd_bus_master_if #(
    parameter int DW     = 16,
    parameter int MAX_RD = 2,
    parameter int RLW    = $clog2(MAX_RD + 1)
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic                 req_rs;
    logic [DW-1:0]        req_wdata;
    logic [RLW-1:0]       req_rd_len;
    logic                 req_fm;
    logic                 rsp_valid;
    logic [DW*MAX_RD-1:0] rsp_rdata;
    logic                 wr_done;
    logic                 busy;

    modport master (
        output req_valid, req_write, req_rs, req_wdata, req_rd_len, req_fm,
        input  req_ready, rsp_valid, rsp_rdata, wr_done, busy
    );

    modport slave (
        input  req_valid, req_write, req_rs, req_wdata, req_rd_len, req_fm,
        output req_ready, rsp_valid, rsp_rdata, wr_done, busy
    );
endinterface

// File: rtl/lcd_bus_master.sv
// -----------------------------------------------------------------------------
// lcd_bus_master
//   8080-style parallel bus master for the LCD controller. Accepts single-word
//   write and multi-word read requests over a valid/ready port and generates
//   the cs/rs/wr/rd strobes with configurable low/high phase lengths. Writes
//   can be streamed back to back with cs held low; a read may follow a write
//   directly. All bus outputs are registered. The pad tristate lives in the
//   LCD top, driven from lcd_data_o / lcd_data_oe.
//
//   Optional build macro LCD_RD_DUMMY_EN: every read request starts with one
//   extra rd cycle pair whose data is discarded (controller dummy read).
//
// Ports
//   pclk, rst      clock, asynchronous active-high reset
//   req_if         request/response port (lcd_bus_master_if.slave)
//   lcd_rst        ~rst, panel reset
//   lcd_bl_ctr     backlight enable, set on the first edge after reset
//   lcd_cs/rs/wr/rd bus strobes (cs, wr, rd active-low)
//   lcd_data_i     bus read data
//   lcd_data_o     bus write data
//   lcd_data_oe    1 = top drives the pad with lcd_data_o
// -----------------------------------------------------------------------------
module lcd_bus_master #(
    parameter int DW      = 16,
    parameter int WR_L    = 1,
    parameter int WR_H    = 1,
    parameter int RD_ID_L = 3,
    parameter int RD_ID_H = 5,
    parameter int RD_FM_L = 8,
    parameter int RD_FM_H = 13,
    parameter int MAX_RD  = 2,
    parameter int RLW     = $clog2(MAX_RD + 1)
) (
    input  logic            pclk,
    input  logic            rst,
    lcd_bus_master_if.slave req_if,
    output logic            lcd_rst,
    output logic            lcd_bl_ctr,
    output logic            lcd_cs,
    output logic            lcd_rs,
    output logic            lcd_wr,
    output logic            lcd_rd,
    input  logic [DW-1:0]   lcd_data_i,
    output logic [DW-1:0]   lcd_data_o,
    output logic            lcd_data_oe
);
    localparam int RW     = DW * MAX_RD;
    localparam int PH_WR  = (WR_L > WR_H) ? WR_L : WR_H;
    localparam int PH_ID  = (RD_ID_L > RD_ID_H) ? RD_ID_L : RD_ID_H;
    localparam int PH_FM  = (RD_FM_L > RD_FM_H) ? RD_FM_L : RD_FM_H;
    localparam int PH_A   = (PH_WR > PH_ID) ? PH_WR : PH_ID;
    localparam int PH_MAX = (PH_A > PH_FM) ? PH_A : PH_FM;
    localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

`ifdef LCD_RD_DUMMY_EN
    localparam logic DUMMY_EN = 1'b1;
`else
    localparam logic DUMMY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_LO,
        S_WR_HI,
        S_RD_LO,
        S_RD_HI
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RLW-1:0] len_q, len_d;
    logic [RLW-1:0] words_q, words_d;
    logic [RLW-1:0] len_eff;
    logic           fm_q, fm_d;
    logic           first_q, first_d;
    logic           dummy_q, dummy_d;
    logic           cs_d, rs_d, wr_d, rd_d, oe_d;
    logic [DW-1:0]  data_d;
    logic [RW-1:0]  rdata_q, rdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           wr_done_q, wr_done_d;
    logic           wr_lo_last, wr_hi_last, rd_lo_last, rd_hi_last;
    logic           ready, accept;

    assign wr_lo_last = (cnt_q == CW'(WR_L - 1));
    assign wr_hi_last = (cnt_q == CW'(WR_H - 1));
    assign rd_lo_last = fm_q ? (cnt_q == CW'(RD_FM_L - 1)) : (cnt_q == CW'(RD_ID_L - 1));
    assign rd_hi_last = fm_q ? (cnt_q == CW'(RD_FM_H - 1)) : (cnt_q == CW'(RD_ID_H - 1));

    // A new request can be taken in IDLE or in the last write-high cycle,
    // which is what lets writes stream without releasing cs.
    assign ready  = ~rst & ((state_q == S_IDLE) | ((state_q == S_WR_HI) & wr_hi_last));
    assign accept = req_if.req_valid & ready;

    assign req_if.req_ready = ready;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_rdata = rdata_q;
    assign req_if.wr_done   = wr_done_q;
    assign req_if.busy      = (state_q != S_IDLE);
    assign lcd_rst          = ~rst;

    // Effective read length: zero means one word, anything above MAX_RD is clamped.
    always_comb begin
        len_eff = req_if.req_rd_len;
        if (req_if.req_rd_len == '0) begin
            len_eff = RLW'(1);
        end else if (req_if.req_rd_len > RLW'(MAX_RD)) begin
            len_eff = RLW'(MAX_RD);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        len_d       = len_q;
        words_d     = words_q;
        fm_d        = fm_q;
        first_d     = first_q;
        dummy_d     = dummy_q;
        cs_d        = lcd_cs;
        rs_d        = lcd_rs;
        wr_d        = lcd_wr;
        rd_d        = lcd_rd;
        oe_d        = lcd_data_oe;
        data_d      = lcd_data_o;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        wr_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                cs_d  = 1'b1;
                wr_d  = 1'b1;
                rd_d  = 1'b1;
                oe_d  = 1'b0;
            end
            S_WR_SETUP: begin
                state_d = S_WR_LO;
                cnt_d   = '0;
                wr_d    = 1'b0;
            end
            S_WR_LO: begin
                if (wr_lo_last) begin
                    state_d   = S_WR_HI;
                    cnt_d     = '0;
                    wr_d      = 1'b1;
                    wr_done_d = 1'b1;
                end
            end
            S_WR_HI: begin
                if (wr_hi_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    oe_d    = 1'b0;
                end
            end
            S_RD_LO: begin
                if (rd_lo_last) begin
                    state_d = S_RD_HI;
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    if (dummy_q) begin
                        dummy_d = 1'b0;
                    end else begin
                        // First real capture of a request wipes the older words.
                        if (first_q) begin
                            rdata_d = RW'(lcd_data_i);
                        end else begin
                            rdata_d = (rdata_q << DW) | RW'(lcd_data_i);
                        end
                        first_d = 1'b0;
                        words_d = words_q + RLW'(1);
                    end
                end
            end
            S_RD_HI: begin
                if (rd_hi_last) begin
                    cnt_d = '0;
                    if (words_q < len_q) begin
                        state_d = S_RD_LO;
                        rd_d    = 1'b0;
                    end else begin
                        state_d     = S_IDLE;
                        cs_d        = 1'b1;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Acceptance overrides the phase decision above (IDLE or last WR_HI cycle).
        if (accept) begin
            cnt_d = '0;
            cs_d  = 1'b0;
            if (req_if.req_write) begin
                state_d = S_WR_SETUP;
                rs_d    = req_if.req_rs;
                data_d  = req_if.req_wdata;
                oe_d    = 1'b1;
                wr_d    = 1'b1;
            end else begin
                state_d = S_RD_LO;
                rs_d    = 1'b1;
                rd_d    = 1'b0;
                oe_d    = 1'b0;
                wr_d    = 1'b1;
                len_d   = len_eff;
                fm_d    = req_if.req_fm;
                words_d = '0;
                first_d = 1'b1;
                dummy_d = DUMMY_EN;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            words_q     <= '0;
            fm_q        <= 1'b0;
            first_q     <= 1'b0;
            dummy_q     <= 1'b0;
            lcd_cs      <= 1'b1;
            lcd_rs      <= 1'b0;
            lcd_wr      <= 1'b1;
            lcd_rd      <= 1'b1;
            lcd_data_o  <= '0;
            lcd_data_oe <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            lcd_bl_ctr  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            words_q     <= words_d;
            fm_q        <= fm_d;
            first_q     <= first_d;
            dummy_q     <= dummy_d;
            lcd_cs      <= cs_d;
            lcd_rs      <= rs_d;
            lcd_wr      <= wr_d;
            lcd_rd      <= rd_d;
            lcd_data_o  <= data_d;
            lcd_data_oe <= oe_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            wr_done_q   <= wr_done_d;
            lcd_bl_ctr  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_bus_master.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_master
//   Self-checking bench for lcd_bus_master with default parameters. Expected
//   write words and read results are queued when requests are issued and are
//   compared when the bus strobes / rsp_valid appear.
// -----------------------------------------------------------------------------
module tb_lcd_bus_master;
    localparam int DW      = 16;
    localparam int MAX_RD  = 2;
    localparam int RLW     = 2;
    localparam int WR_L    = 1;
    localparam int WR_H    = 1;
    localparam int RD_ID_L = 3;
    localparam int RD_ID_H = 5;
    localparam int RD_FM_L = 8;
    localparam int RD_FM_H = 13;
`ifdef LCD_RD_DUMMY_EN
    localparam int DUMMY = 1;
`else
    localparam int DUMMY = 0;
`endif

    logic          pclk = 1'b0;
    logic          rst  = 1'b0;
    logic [DW-1:0] lcd_data_i = '0;
    logic          lcd_rst, lcd_bl_ctr, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe;
    logic [DW-1:0] lcd_data_o;

    lcd_bus_master_if #(.DW(DW), .MAX_RD(MAX_RD), .RLW(RLW)) u_if ();

    lcd_bus_master #(
        .DW(DW), .WR_L(WR_L), .WR_H(WR_H),
        .RD_ID_L(RD_ID_L), .RD_ID_H(RD_ID_H),
        .RD_FM_L(RD_FM_L), .RD_FM_H(RD_FM_H),
        .MAX_RD(MAX_RD), .RLW(RLW)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .req_if     (u_if.slave),
        .lcd_rst    (lcd_rst),
        .lcd_bl_ctr (lcd_bl_ctr),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_wr     (lcd_wr),
        .lcd_rd     (lcd_rd),
        .lcd_data_i (lcd_data_i),
        .lcd_data_o (lcd_data_o),
        .lcd_data_oe(lcd_data_oe)
    );

    always #5 pclk = ~pclk;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_wr_done   = 0;
    int n_rsp       = 0;
    int last_cs_run = 0;
    int saved_wd    = 0;
    bit cur_fm      = 1'b0;

    logic [16:0] wq[$];
    logic [31:0] rq[$];
    logic [15:0] bus_q[$];

    // monitor state
    bit prev_wr = 1'b1, prev_rd = 1'b1, prev_cs = 1'b1, hi_act = 1'b0;
    int lo_cnt = 0, hi_cnt = 0, wlo_cnt = 0, cs_cnt = 0;
    logic [16:0] wexp;
    logic [31:0] rexp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rd_lo_len(input bit fm);
        return fm ? RD_FM_L : RD_ID_L;
    endfunction

    function automatic int rd_hi_len(input bit fm);
        return fm ? RD_FM_H : RD_ID_H;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic drive_req(input bit wr, input bit rs, input logic [15:0] d,
                             input logic [1:0] len, input bit fm);
        int guard;
        u_if.req_valid  = 1'b1;
        u_if.req_write  = wr;
        u_if.req_rs     = rs;
        u_if.req_wdata  = d;
        u_if.req_rd_len = len;
        u_if.req_fm     = fm;
        guard = 0;
        while (!u_if.req_ready && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        if (!u_if.req_ready) begin
            check_eq("req_accept", 64'(u_if.req_ready), 64'd1);
            u_if.req_valid = 1'b0;
        end else begin
            @(negedge pclk);
            u_if.req_valid  = 1'b0;
            // scramble request fields: the DUT must have latched them already
            u_if.req_wdata  = 16'($urandom);
            u_if.req_rs     = ~rs;
            u_if.req_fm     = ~fm;
            u_if.req_rd_len = 2'($urandom);
        end
    endtask

    task automatic do_write(input bit rs, input logic [15:0] d);
        wq.push_back({rs, d});
        drive_req(1'b1, rs, d, 2'd0, 1'b0);
    endtask

    task automatic do_read(input logic [1:0] len, input bit fm,
                           input logic [15:0] w0, input logic [15:0] w1);
        int n;
        n = (len == 2'd0) ? 1 : ((int'(len) > MAX_RD) ? MAX_RD : int'(len));
        cur_fm = fm;
        if (DUMMY != 0) bus_q.push_back(16'hDEAD);
        bus_q.push_back(w0);
        if (n == 2) begin
            bus_q.push_back(w1);
            rq.push_back({w0, w1});
        end else begin
            rq.push_back({16'h0000, w0});
        end
        drive_req(1'b0, 1'b1, 16'h0000, len, fm);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (u_if.busy && guard < 500) begin
            @(negedge pclk);
            guard++;
        end
        check_eq("idle_wait", 64'(u_if.busy), 64'd0);
        @(negedge pclk);
    endtask

    // Bus monitor: strobe timing, write data, read data feed, responses.
    initial begin
        forever begin
            @(negedge pclk);
            if (rst) begin
                prev_wr = 1'b1;
                prev_rd = 1'b1;
                prev_cs = 1'b1;
                hi_act  = 1'b0;
                cs_cnt  = 0;
            end else begin
                if (prev_wr && !lcd_wr) begin
                    wlo_cnt = 1;
                    if (wq.size() == 0) begin
                        check_eq("wr_unexpected", 64'(lcd_wr), 64'd1);
                    end else begin
                        wexp = wq.pop_front();
                        check_eq("wr_data", 64'({lcd_rs, lcd_data_o}), 64'(wexp));
                        check_eq("wr_oe_cs", 64'({lcd_data_oe, lcd_cs}), 64'(2'b10));
                    end
                end else if (!prev_wr && !lcd_wr) begin
                    wlo_cnt++;
                end else if (!prev_wr && lcd_wr) begin
                    check_eq("wr_low_len", 64'(wlo_cnt), 64'(WR_L));
                    check_eq("wr_done_at_rise", 64'(u_if.wr_done), 64'd1);
                end
                if (u_if.wr_done) n_wr_done++;

                if (prev_rd && !lcd_rd) begin
                    if (hi_act) check_eq("rd_high_len", 64'(hi_cnt), 64'(rd_hi_len(cur_fm)));
                    hi_act = 1'b0;
                    lo_cnt = 1;
                    check_eq("rd_oe_off", 64'({lcd_data_oe, lcd_rs}), 64'(2'b01));
                    lcd_data_i = (bus_q.size() != 0) ? bus_q.pop_front() : 16'h0000;
                end else if (!prev_rd && !lcd_rd) begin
                    lo_cnt++;
                end else if (!prev_rd && lcd_rd) begin
                    check_eq("rd_low_len", 64'(lo_cnt), 64'(rd_lo_len(cur_fm)));
                    hi_act = 1'b1;
                    hi_cnt = 1;
                end else if (hi_act) begin
                    if (u_if.rsp_valid) begin
                        check_eq("rd_high_len_last", 64'(hi_cnt), 64'(rd_hi_len(cur_fm)));
                        hi_act = 1'b0;
                    end else begin
                        hi_cnt++;
                    end
                end

                if (u_if.rsp_valid) begin
                    n_rsp++;
                    if (rq.size() == 0) begin
                        check_eq("rsp_unexpected", 64'(u_if.rsp_valid), 64'd0);
                    end else begin
                        rexp = rq.pop_front();
                        check_eq("rsp_rdata", 64'(u_if.rsp_rdata), 64'(rexp));
                    end
                end

                if (!lcd_cs) begin
                    cs_cnt++;
                end else if (!prev_cs) begin
                    last_cs_run = cs_cnt;
                    cs_cnt = 0;
                end
                prev_wr = lcd_wr;
                prev_rd = lcd_rd;
                prev_cs = lcd_cs;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.req_valid  = 1'b0;
        u_if.req_write  = 1'b0;
        u_if.req_rs     = 1'b0;
        u_if.req_wdata  = '0;
        u_if.req_rd_len = '0;
        u_if.req_fm     = 1'b0;

        // reset
        #1 rst = 1'b1;
        repeat (2) @(negedge pclk);
        check_eq("rst_strobes", 64'({lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe}), 64'(5'b10110));
        check_eq("rst_data_o", 64'(lcd_data_o), 64'd0);
        check_eq("rst_flags", 64'({u_if.req_ready, u_if.busy, u_if.rsp_valid, u_if.wr_done,
                                   lcd_bl_ctr, lcd_rst}), 64'd0);
        check_eq("rst_rdata", 64'(u_if.rsp_rdata), 64'd0);
        #2 rst = 1'b0;
        #1 check_eq("bl_before_edge", 64'(lcd_bl_ctr), 64'd0);
        @(negedge pclk);
        check_eq("idle_after_rst", 64'({lcd_cs, lcd_wr, lcd_rd, lcd_data_oe, u_if.req_ready,
                                        lcd_bl_ctr, lcd_rst, u_if.busy}), 64'(8'b11101110));

        // single command write
        do_write(1'b0, 16'h002C);
        check_eq("wr_busy", 64'(u_if.busy), 64'd1);
        wait_idle();
        check_eq("wr_cs_run", 64'(last_cs_run), 64'd3);
        check_eq("wr_done_cnt1", 64'(n_wr_done), 64'd1);

        // streamed pixel writes
        do_write(1'b1, 16'hF800);
        do_write(1'b1, 16'h07E0);
        do_write(1'b1, 16'h001F);
        wait_idle();
        check_eq("stream_cs_run", 64'(last_cs_run), 64'd9);
        check_eq("wr_done_cnt4", 64'(n_wr_done), 64'd4);

        // reads
        do_read(2'd1, 1'b0, 16'h9341, 16'h0000);
        wait_idle();
        check_eq("rsp_cnt_id", 64'(n_rsp), 64'd1);
        repeat (3) @(negedge pclk);
        check_eq("rdata_hold", 64'(u_if.rsp_rdata), 64'h0000_9341);
        do_read(2'd2, 1'b1, 16'hAAAA, 16'h5555);
        wait_idle();
        do_read(2'd0, 1'b0, 16'h1234, 16'h0000);
        wait_idle();
        do_read(2'd3, 1'b0, 16'h0F0F, 16'hF0F0);
        wait_idle();
        check_eq("rsp_cnt_rd", 64'(n_rsp), 64'd4);

        // write directly followed by a read
        do_write(1'b1, 16'h1111);
        do_read(2'd1, 1'b0, 16'h4444, 16'h0000);
        wait_idle();
        check_eq("wr_rd_cs_run", 64'(last_cs_run), 64'(3 + (1 + DUMMY) * (RD_ID_L + RD_ID_H)));
        check_eq("rsp_cnt_wr_rd", 64'(n_rsp), 64'd5);

        // reset while wr is low
        do_write(1'b1, 16'hBEEF);
        @(negedge pclk);
        check_eq("abort_in_wr_lo", 64'(lcd_wr), 64'd0);
        saved_wd = n_wr_done;
        #2 rst = 1'b1;
        #1;
        check_eq("abort_strobes", 64'({lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe}), 64'(5'b10110));
        check_eq("abort_data_o", 64'(lcd_data_o), 64'd0);
        check_eq("abort_flags", 64'({u_if.req_ready, u_if.busy, u_if.wr_done, lcd_bl_ctr, lcd_rst}),
                 64'd0);
        repeat (2) @(negedge pclk);
        #2 rst = 1'b0;
        @(negedge pclk);
        check_eq("abort_no_wr_done", 64'(n_wr_done), 64'(saved_wd));
        do_write(1'b0, 16'h0029);
        wait_idle();
        check_eq("post_abort_cs_run", 64'(last_cs_run), 64'd3);
        check_eq("post_abort_wr_done", 64'(n_wr_done), 64'(saved_wd + 1));

        // scoreboard drained
        check_eq("wq_empty", 64'(wq.size()), 64'd0);
        check_eq("rq_empty", 64'(rq.size()), 64'd0);
        check_eq("bus_q_empty", 64'(bus_q.size()), 64'd0);
        check_eq("total_wr_done", 64'(n_wr_done), 64'd6);
        check_eq("total_rsp", 64'(n_rsp), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
